pixel_stream_feeder: RTL and testbench
======================================

Name: pixel_stream_feeder

Overview:
- Transmit-side partner of the 3x3 window line-buffer receiver (4 line buffers of LINE_WIDTH pixels).
- Accepts a frame from an upstream valid/ready source and drives the receiver's pixel/pixel_valid input, which has no backpressure.
- Keeps a mirrored count of pixels buffered inside the receiver, using its window_valid as the drain indication, and throttles upstream so buffered lines are never overwritten.
- Sits between the frame DMA/reader and the window generator.

Parameters:
- DATA_WIDTH, 32, pixel width.
- LINE_WIDTH, 512, pixels per line.
- FRAME_ROWS, 512, lines per frame.
- MAX_OCC, 2047, highest permitted buffered-pixel count (4*LINE_WIDTH-1).
- RD_THRESHOLD, 1422, occupancy at which the receiver begins a line read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- s_pixel  in  DATA_WIDTH  upstream pixel
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- pixel  out  DATA_WIDTH  to receiver, registered
- pixel_valid  out  1  to receiver, registered
- window_valid  in  1  receiver read strobe (one pixel drained per cycle)
- occupancy  out  12  mirrored buffered-pixel count
- busy  out  1  high from the cycle after start until DONE exits
- frame_done  out  1  one-cycle pulse at end of frame
- err_underflow  out  1  sticky: window_valid seen while occupancy==0

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high, and clears all state.
- Reset values:
  - pixel=0, pixel_valid=0, s_ready=0, occupancy=0, busy=0, frame_done=0, err_underflow=0.
  - State=IDLE; column and row counters=0.
- States: IDLE, STREAM, DRAIN, DONE (PAD_TOP and PAD_BOT added when the optional feature is compiled in).
- IDLE:
  - start moves to STREAM (or to PAD_TOP with the feature); busy=1 from the next cycle.
  - start is ignored in any other state.
- STREAM:
  - s_ready = (occupancy + pixel_valid) < MAX_OCC, combinational.
  - Transfer occurs on s_valid & s_ready; the next cycle has pixel<=s_pixel and pixel_valid<=1. Otherwise pixel_valid<=0 and pixel holds its value. Latency is 1 cycle.
  - Column counter wraps at LINE_WIDTH-1 and increments the row counter.
  - Transfer of pixel (FRAME_ROWS-1, LINE_WIDTH-1) goes to DRAIN (or PAD_BOT).
- Occupancy (driven by registered pixel_valid, which is what the receiver sees):
  - pixel_valid & !window_valid: +1.
  - !pixel_valid & window_valid: -1.
  - Both or neither: unchanged.
  - Saturates at 0; decrement at 0 sets err_underflow (cleared only by reset).
- DRAIN:
  - s_ready=0; waits until pixel_valid==0 and occupancy < RD_THRESHOLD.
  - The receiver stops reading below RD_THRESHOLD, so the residual count is the expected frame tail.
  - Then goes to DONE.
- DONE: frame_done=1 for one cycle, busy<=0, next state IDLE. Occupancy is retained, not cleared, across frames.
- Upstream: s_valid may drop at any time (gaps are legal); s_pixel must be stable while s_valid & !s_ready.
- Reset mid-frame: immediate return to IDLE with all counters zero. The receiver shares reset, so the mirror stays consistent.

Optional Feature:
- Macro: PIXEL_FEEDER_BORDER_PAD_EN.
- Defined:
  - PAD_TOP emits LINE_WIDTH zero pixels (pixel_valid=1, subject to the same occupancy limit, s_ready=0) before the first real row.
  - PAD_BOT emits LINE_WIDTH zeros after the last real row, before DRAIN.
  - Windows then exist for rows 0 and FRAME_ROWS-1.
- Undefined: no pad states; top and bottom image rows get no centred window.

Decomposition:
- Shared package holds:
  - The state enum.
  - LINE_WIDTH, FRAME_ROWS, DATA_WIDTH, RD_THRESHOLD, and the derived LB_DEPTH = 4*LINE_WIDTH.
- One natural sub-module: occupancy_tracker (up/down saturating counter with underflow flag).
- FSM and output register stay in the top.

Test Plan:
- Reset mid-stream after 700 pixels -> next cycle occupancy=0, pixel_valid=0, s_ready=0, busy=0; new start streams from row 0 col 0.
- Continuous s_valid, window_valid=0 -> exactly 2047 pixels accepted; s_ready low thereafter; occupancy=2047.
- Occupancy 2047, pulse window_valid 1 cycle -> occupancy 2046; s_ready=1 for one transfer; new pixel appears on pixel 1 cycle after acceptance.
- pixel_valid and window_valid high in the same cycle -> occupancy unchanged.
- window_valid at occupancy 0 -> occupancy stays 0; err_underflow=1 and persists until reset.
- Full 512x512 frame with a receiver model reading 512 pixels whenever occupancy>=1422 -> 262144 pixels emitted in order; frame_done pulses once after occupancy<1422.
  - With PIXEL_FEEDER_BORDER_PAD_EN defined: 263168 pixels emitted, of which the first 512 and last 512 are zero.

Source files
------------

// File: rtl/pixel_stream_feeder_pkg.sv
// Shared types and default geometry for the pixel stream feeder.
// The state enum gains PAD_TOP/PAD_BOT when PIXEL_FEEDER_BORDER_PAD_EN is defined.
package pixel_stream_feeder_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int LINE_WIDTH   = 512;
    localparam int FRAME_ROWS   = 512;
    localparam int LB_DEPTH     = 4 * LINE_WIDTH;
    localparam int MAX_OCC      = LB_DEPTH - 1;
    localparam int RD_THRESHOLD = 1422;
    localparam int OCC_WIDTH    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
        ,
        ST_PAD_TOP,
        ST_PAD_BOT
`endif
    } state_t;

endpackage

// File: rtl/pixel_stream_feeder_if.sv
// Upstream valid/ready pixel bus plus the receiver-facing pixel stream.
// master: the feeder itself; slave: the surrounding source/receiver side.
interface pixel_stream_feeder_if #(
    parameter int DATA_WIDTH = pixel_stream_feeder_pkg::DATA_WIDTH
);
    import pixel_stream_feeder_pkg::*;

    logic [DATA_WIDTH-1:0] s_pixel;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  pixel_valid;
    logic                  window_valid;

    modport master (
        input  s_pixel,
        input  s_valid,
        input  window_valid,
        output s_ready,
        output pixel,
        output pixel_valid
    );

    modport slave (
        output s_pixel,
        output s_valid,
        output window_valid,
        input  s_ready,
        input  pixel,
        input  pixel_valid
    );

endinterface

// File: rtl/pixel_stream_feeder_occupancy_tracker.sv
// Up/down counter mirroring how many pixels sit inside the receiver's line
// buffers. Never wraps below zero; a drain request at zero raises a sticky flag.
module occupancy_tracker
    import pixel_stream_feeder_pkg::*;
#(
    parameter int WIDTH = OCC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_underflow
);

    logic [WIDTH-1:0] r_count;
    logic             r_underflow;

    // Count pixels in minus pixels drained; simultaneous in/out cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count != '1) begin
                r_count <= r_count + WIDTH'(1);
            end
        end else if (!i_inc && i_dec) begin
            if (r_count == '0) begin
                r_underflow <= 1'b1;
            end else begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_count     = r_count;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/pixel_stream_feeder.sv
// Feeds one frame from a valid/ready source into the 3x3 window receiver,
// whose pixel input has no backpressure. A mirrored occupancy count throttles
// the source so the receiver's line buffers are never overrun.
// Optional feature macro: PIXEL_FEEDER_BORDER_PAD_EN (adds one zero line
// above and below the frame).
module pixel_stream_feeder #(
    parameter int DATA_WIDTH   = pixel_stream_feeder_pkg::DATA_WIDTH,
    parameter int LINE_WIDTH   = pixel_stream_feeder_pkg::LINE_WIDTH,
    parameter int FRAME_ROWS   = pixel_stream_feeder_pkg::FRAME_ROWS,
    parameter int MAX_OCC      = pixel_stream_feeder_pkg::MAX_OCC,
    parameter int RD_THRESHOLD = pixel_stream_feeder_pkg::RD_THRESHOLD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    pixel_stream_feeder_if.master        bus,
    output logic [11:0]                  occupancy,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_underflow
);
    import pixel_stream_feeder_pkg::*;

    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int ROW_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(FRAME_ROWS - 1);
    localparam logic [12:0]      MAX_OCC_V = 13'(MAX_OCC);
    localparam logic [11:0]      RD_THR_V  = 12'(RD_THRESHOLD);

    state_t                r_state;
    state_t                w_state_next;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      w_col_next;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      w_row_next;
    logic [DATA_WIDTH-1:0] r_pixel;
    logic                  r_pixel_valid;
    logic                  r_busy;
    logic                  w_busy_set;
    logic                  w_busy_clr;
    logic                  w_s_ready;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_emit_data;
    logic [11:0]           w_occ;
    logic                  w_underflow;
    logic [12:0]           w_proj;
    logic                  w_room;

    // The pixel on the wire this cycle is not counted yet, so include it
    // when deciding whether one more pixel still fits.
    assign w_proj = {1'b0, w_occ} + {12'b0, r_pixel_valid};
    assign w_room = (w_proj < MAX_OCC_V);

    occupancy_tracker #(
        .WIDTH(12)
    ) u_occ (
        .clk        (clk),
        .reset      (reset),
        .i_inc      (r_pixel_valid),
        .i_dec      (bus.window_valid),
        .o_count    (w_occ),
        .o_underflow(w_underflow)
    );

    // Next-state, emit decision and raster position update.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_s_ready    = 1'b0;
        w_emit       = 1'b0;
        w_emit_data  = '0;
        w_busy_set   = 1'b0;
        w_busy_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_set = 1'b1;
                    w_col_next = '0;
                    w_row_next = '0;
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
                    w_state_next = ST_PAD_TOP;
`else
                    w_state_next = ST_STREAM;
`endif
                end
            end
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
            ST_PAD_TOP: begin
                if (w_room) begin
                    w_emit = 1'b1;
                    if (r_col == LAST_COL) begin
                        w_col_next   = '0;
                        w_state_next = ST_STREAM;
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
            ST_PAD_BOT: begin
                if (w_room) begin
                    w_emit = 1'b1;
                    if (r_col == LAST_COL) begin
                        w_col_next   = '0;
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
`endif
            ST_STREAM: begin
                w_s_ready = w_room;
                if (bus.s_valid && w_room) begin
                    w_emit      = 1'b1;
                    w_emit_data = bus.s_pixel;
                    if (r_col == LAST_COL) begin
                        w_col_next = '0;
                        if (r_row == LAST_ROW) begin
                            w_row_next = '0;
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
                            w_state_next = ST_PAD_BOT;
`else
                            w_state_next = ST_DRAIN;
`endif
                        end else begin
                            w_row_next = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_next = r_col + COL_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Receiver stops reading below the threshold, so what remains is the frame tail.
                if (!r_pixel_valid && (w_occ < RD_THR_V)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy_clr   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters, registered pixel output and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_col         <= w_col_next;
            r_row         <= w_row_next;
            r_pixel_valid <= w_emit;
            if (w_emit) begin
                r_pixel <= w_emit_data;
            end
            if (w_busy_set) begin
                r_busy <= 1'b1;
            end else if (w_busy_clr) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.pixel       = r_pixel;
    assign bus.pixel_valid = r_pixel_valid;
    assign occupancy       = w_occ;
    assign busy            = r_busy;
    assign frame_done      = (r_state == ST_DONE);
    assign err_underflow   = w_underflow;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Self-checking bench for pixel_stream_feeder on a reduced frame geometry.
// Reference: scoreboard of accepted pixels (plus pad zeros when
// PIXEL_FEEDER_BORDER_PAD_EN is defined) and an occupancy figure computed as
// pixels delivered to the receiver minus pixels it read.
module tb_pixel_stream_feeder;

    localparam int DW        = 16;
    localparam int LW        = 16;
    localparam int FR        = 6;
    localparam int MAXO      = 4 * LW - 1;
    localparam int RDT       = 44;
    localparam int FRAME_PIX = LW * FR;
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
    localparam int PAD_PIX = LW;
`else
    localparam int PAD_PIX = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] occupancy;
    logic        busy;
    logic        frame_done;
    logic        err_underflow;

    pixel_stream_feeder_if #(.DATA_WIDTH(DW)) bus ();

    pixel_stream_feeder #(
        .DATA_WIDTH  (DW),
        .LINE_WIDTH  (LW),
        .FRAME_ROWS  (FR),
        .MAX_OCC     (MAXO),
        .RD_THRESHOLD(RDT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .occupancy    (occupancy),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad = 0;
    int              m_occ = 0;
    bit              m_err = 1'b0;
    bit              m_pv = 1'b0;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   cur_pix;
    int              n_acc = 0;
    int              n_emit = 0;
    int              n_done = 0;

    // One clock cycle: drive at negedge, let the edge happen, check at next negedge.
    task automatic cycle(input bit st, input bit sv, input bit wv);
        bit            acc;
        bit            pv_cyc;
        logic [DW-1:0] want;
        start            = st;
        bus.s_valid      = sv;
        bus.s_pixel      = cur_pix;
        bus.window_valid = wv;
        acc = sv && (bus.s_ready === 1'b1);
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
        pv_cyc = (bus.pixel_valid === 1'b1);
`else
        pv_cyc = m_pv;
`endif
        @(posedge clk);
        if (pv_cyc && !wv) m_occ++;
        else if (!pv_cyc && wv) begin
            if (m_occ == 0) m_err = 1'b1;
            else m_occ--;
        end
        m_pv = acc;
        if (acc) begin
            exp_q.push_back(cur_pix);
            n_acc++;
            cur_pix = DW'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (occupancy !== 12'(m_occ)) begin
            bad++;
            $display("FAIL occupancy: got %0d want %0d", occupancy, m_occ);
        end
        total++;
        if (err_underflow !== m_err) begin
            bad++;
            $display("FAIL err_underflow: got %b want %b", err_underflow, m_err);
        end
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
        if (acc) begin
            total++;
            if (bus.pixel_valid !== 1'b1) begin
                bad++;
                $display("FAIL latency: pixel_valid got %b want 1", bus.pixel_valid);
            end
        end
`else
        total++;
        if (bus.pixel_valid !== acc) begin
            bad++;
            $display("FAIL latency: pixel_valid got %b want %b", bus.pixel_valid, acc);
        end
`endif
        if (bus.pixel_valid === 1'b1) begin
            n_emit++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL order: got pixel %h want none pending", bus.pixel);
            end else begin
                want = exp_q.pop_front();
                if (bus.pixel !== want) begin
                    bad++;
                    $display("FAIL order: got pixel %h want %h", bus.pixel, want);
                end else begin
                    $display("emit %0d pixel=%h occ=%0d", n_emit, bus.pixel, occupancy);
                end
            end
        end
        if (frame_done === 1'b1) n_done++;
    endtask

    task automatic clear_model();
        m_occ = 0;
        m_err = 1'b0;
        m_pv  = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        start            = 1'b0;
        bus.s_valid      = 1'b0;
        bus.window_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic start_frame();
`ifdef PIXEL_FEEDER_BORDER_PAD_EN
        for (int i = 0; i < LW; i++) exp_q.push_back('0);
`endif
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.pixel !== '0)          begin bad++; $display("FAIL rst_pixel: got %h want 0", bus.pixel); end
        total++; if (bus.pixel_valid !== 1'b0)  begin bad++; $display("FAIL rst_pixel_valid: got %b want 0", bus.pixel_valid); end
        total++; if (bus.s_ready !== 1'b0)      begin bad++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        total++; if (occupancy !== 12'd0)       begin bad++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        total++; if (busy !== 1'b0)             begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (frame_done !== 1'b0)       begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        total++; if (err_underflow !== 1'b0)    begin bad++; $display("FAIL rst_err: got %b want 0", err_underflow); end
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_fill();
        int a0;
        a0 = n_acc;
        start_frame();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy: got %b want 1", busy); end
        repeat (MAXO + LW + 10) cycle(1'b0, 1'b1, 1'b0);
        total++; if (n_acc - a0 != MAXO - PAD_PIX) begin bad++; $display("FAIL fill_count: got %0d want %0d", n_acc - a0, MAXO - PAD_PIX); end
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b want 0", bus.s_ready); end
        total++; if (occupancy !== 12'(MAXO)) begin bad++; $display("FAIL fill_occ: got %0d want %0d", occupancy, MAXO); end
        $display("test_fill done accepted=%0d", n_acc - a0);
    endtask

    task automatic test_one_read();
        int a0;
        cycle(1'b0, 1'b1, 1'b1);
        total++; if (occupancy !== 12'(MAXO - 1)) begin bad++; $display("FAIL read_occ: got %0d want %0d", occupancy, MAXO - 1); end
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL read_ready: got %b want 1", bus.s_ready); end
        a0 = n_acc;
        repeat (8) cycle(1'b0, 1'b1, 1'b0);
        total++; if (n_acc - a0 != 1) begin bad++; $display("FAIL read_accepts: got %0d want 1", n_acc - a0); end
        total++; if (occupancy !== 12'(MAXO)) begin bad++; $display("FAIL read_refill: got %0d want %0d", occupancy, MAXO); end
        $display("test_one_read done");
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (bus.pixel_valid !== 1'b1) begin bad++; $display("FAIL simul_pv: got %b want 1", bus.pixel_valid); end
        cycle(1'b0, 1'b0, 1'b1);
        total++; if (occupancy !== 12'(MAXO - 1)) begin bad++; $display("FAIL simul_occ: got %0d want %0d", occupancy, MAXO - 1); end
        do_reset();
        $display("test_simultaneous done");
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b1);
        total++; if (occupancy !== 12'd0) begin bad++; $display("FAIL uflow_occ: got %0d want 0", occupancy); end
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uflow_set: got %b want 1", err_underflow); end
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uflow_sticky: got %b want 1", err_underflow); end
        do_reset();
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uflow_clear: got %b want 0", err_underflow); end
        $display("test_underflow done");
    endtask

    task automatic test_reset_mid();
        int a0;
        int guard;
        a0 = n_acc;
        guard = 0;
        start_frame();
        while ((n_acc - a0 < 40) && (guard < 400)) begin
            cycle(1'b0, ($urandom_range(0, 2) != 0), 1'b0);
            guard++;
        end
        total++; if (n_acc - a0 != 40) begin bad++; $display("FAIL mid_accepts: got %0d want 40", n_acc - a0); end
        reset = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (occupancy !== 12'd0)      begin bad++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
        total++; if (bus.pixel_valid !== 1'b0) begin bad++; $display("FAIL mid_pv: got %b want 0", bus.pixel_valid); end
        total++; if (bus.s_ready !== 1'b0)     begin bad++; $display("FAIL mid_ready: got %b want 0", bus.s_ready); end
        total++; if (busy !== 1'b0)            begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        reset = 1'b0;
        clear_model();
        $display("test_reset_mid done");
    endtask

    task automatic test_frame();
        int a0, d0, e0, burst, guard;
        bit wv, sv, bot_pushed;
        a0 = n_acc; d0 = n_done; e0 = n_emit;
        burst = 0; guard = 0; bot_pushed = 1'b0;
        start_frame();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy: got %b want 1", busy); end
        while ((n_done == d0) && (guard < 5000)) begin
            if ((burst == 0) && (m_occ >= RDT)) burst = LW;
            wv = (burst > 0);
            if (wv) burst--;
            sv = (n_acc - a0 < FRAME_PIX) && ($urandom_range(0, 3) != 0);
            cycle(1'b0, sv, wv);
            if ((PAD_PIX > 0) && (n_acc - a0 == FRAME_PIX) && !bot_pushed) begin
                for (int i = 0; i < PAD_PIX; i++) exp_q.push_back('0);
                bot_pushed = 1'b1;
            end
            guard++;
        end
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL frame_done_seen: got %0d want 1 (cycles %0d)", n_done - d0, guard); end
        total++; if (occupancy >= 12'(RDT)) begin bad++; $display("FAIL frame_tail_occ: got %0d want below %0d", occupancy, RDT); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy_at_done: got %b want 1", busy); end
        total++; if (n_acc - a0 != FRAME_PIX) begin bad++; $display("FAIL frame_accepts: got %0d want %0d", n_acc - a0, FRAME_PIX); end
        total++; if (n_emit - e0 != FRAME_PIX + 2 * PAD_PIX) begin bad++; $display("FAIL frame_emits: got %0d want %0d", n_emit - e0, FRAME_PIX + 2 * PAD_PIX); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frame_leftover: got %0d want 0", exp_q.size()); end
        cycle(1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_after: got %b want 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_pulse: got %b want 0", frame_done); end
        repeat (5) cycle(1'b0, 1'b1, 1'b0);
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", n_done - d0); end
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL frame_err: got %b want 0", err_underflow); end
        $display("test_frame done emitted=%0d", n_emit - e0);
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        bus.s_valid      = 1'b0;
        bus.s_pixel      = '0;
        bus.window_valid = 1'b0;
        cur_pix          = DW'($urandom);
        test_reset();
        test_fill();
        test_one_read();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
